// File: rtl/nn_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nn_pkg : state encoding, buffer codes and MLP layer table                |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
package nn_pkg;

  typedef enum logic [3:0] {
    ST_IDLE         = 4'd0,
    ST_WAIT_DATA    = 4'd1,
    ST_MM_START     = 4'd2,
    ST_MM_WAIT      = 4'd3,
    ST_RELU_START   = 4'd4,
    ST_RELU_WAIT    = 4'd5,
    ST_NEXT         = 4'd6,
    ST_ARGMAX_START = 4'd7,
    ST_ARGMAX_WAIT  = 4'd8,
    ST_DONE         = 4'd9,
    ST_ERROR        = 4'd10
  } state_t;

  localparam logic [1:0] SRC_IMG = 2'd0;
  localparam logic [1:0] SRC_A   = 2'd1;
  localparam logic [1:0] SRC_B   = 2'd2;

  localparam int NUM_CLASSES  = 10;
  localparam int TABLE_LAYERS = 4;

  // 784-64-64-32-10 network; the last layer feeds argmax without relu
  localparam logic [9:0] LAYER_N    [TABLE_LAYERS] = '{10'd64,  10'd64, 10'd32, 10'd10};
  localparam logic [9:0] LAYER_K    [TABLE_LAYERS] = '{10'd784, 10'd64, 10'd64, 10'd32};
  localparam logic       LAYER_RELU [TABLE_LAYERS] = '{1'b1, 1'b1, 1'b1, 1'b0};

  // Input of a layer is the previous layer's destination buffer
  function automatic logic [1:0] src_for_layer(input logic [1:0] idx);
    if (idx == 2'd0) return SRC_IMG;
    return idx[0] ? SRC_A : SRC_B;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nn_watchdog.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nn_watchdog : wait-state cycle counter, expires at TIMEOUT_CYCLES-1      |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module nn_watchdog #(
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int               CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturates at LAST so a stalled owner never sees the count wrap
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign expire = enable && (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/nn_layer_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nn_layer_sequencer : time-shares mm/relu engines over all MLP layers     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module nn_layer_sequencer
  import nn_pkg::*;
#(
  parameter int NUM_LAYERS     = 4,
  parameter int DIM_W          = 10,
  parameter int CLASS_W        = 4,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               abort,
  input  logic               data_ready,
  input  logic               mm_done,
  input  logic               relu_done,
  input  logic               argmax_done,
  input  logic [CLASS_W-1:0] argmax_index,
  output logic               mm_start,
  output logic [DIM_W-1:0]   mm_n,
  output logic [DIM_W-1:0]   mm_k,
  output logic               relu_start,
  output logic [DIM_W-1:0]   relu_d,
  output logic               argmax_start,
  output logic [DIM_W-1:0]   argmax_size,
  output logic [1:0]         src_sel,
  output logic               dst_sel,
  output logic [1:0]         wgt_sel,
  output logic [1:0]         layer_idx,
  output logic               busy,
  output logic               done,
  output logic [CLASS_W-1:0] result,
  output logic               timeout_err
);

  localparam logic [1:0] LAST_LAYER = 2'(NUM_LAYERS - 1);

  state_t             state_q, state_d;
  logic [1:0]         layer_idx_q, layer_idx_d;
  logic [DIM_W-1:0]   mm_n_q, mm_n_d, mm_k_q, mm_k_d, relu_d_q, relu_d_d;
  logic [DIM_W-1:0]   argmax_size_q, argmax_size_d;
  logic [1:0]         src_sel_q, src_sel_d, wgt_sel_q, wgt_sel_d;
  logic               dst_sel_q, dst_sel_d;
  logic [CLASS_W-1:0] result_q, result_d;
  logic               timeout_err_q, timeout_err_d;
  logic               load_cfg, wd_clear, wd_enable, wd_expire;

  always_comb begin
    state_d       = state_q;
    layer_idx_d   = layer_idx_q;
    result_d      = result_q;
    timeout_err_d = timeout_err_q;
    unique case (state_q)
      ST_IDLE: if (start) begin
        state_d       = ST_WAIT_DATA;
        timeout_err_d = 1'b0;
      end
      ST_WAIT_DATA: begin
        if (data_ready)     state_d = ST_MM_START;
        else if (wd_expire) state_d = ST_ERROR;
      end
      ST_MM_START: state_d = ST_MM_WAIT;
      ST_MM_WAIT: begin
        if (mm_done)        state_d = LAYER_RELU[layer_idx_q] ? ST_RELU_START : ST_NEXT;
        else if (wd_expire) state_d = ST_ERROR;
      end
      ST_RELU_START: state_d = ST_RELU_WAIT;
      ST_RELU_WAIT: begin
        if (relu_done)      state_d = ST_NEXT;
        else if (wd_expire) state_d = ST_ERROR;
      end
      ST_NEXT: begin
        if (layer_idx_q == LAST_LAYER) begin
          state_d = ST_ARGMAX_START;
        end else begin
          layer_idx_d = layer_idx_q + 2'd1;
          state_d     = ST_MM_START;
        end
      end
      ST_ARGMAX_START: state_d = ST_ARGMAX_WAIT;
      ST_ARGMAX_WAIT: begin
        if (argmax_done) begin
          result_d = argmax_index;
          state_d  = ST_DONE;
        end else if (wd_expire) begin
          state_d = ST_ERROR;
        end
      end
      ST_DONE: begin
        state_d     = ST_IDLE;
        layer_idx_d = 2'd0;
      end
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_IDLE;
    endcase
    if ((state_d == ST_ERROR) && (state_q != ST_ERROR)) timeout_err_d = 1'b1;
    // abort wins over everything, but leaves result and the error flag alone
    if (abort) begin
      state_d       = ST_IDLE;
      layer_idx_d   = 2'd0;
      result_d      = result_q;
      timeout_err_d = timeout_err_q;
    end
  end

  assign load_cfg      = (state_d == ST_MM_START) && (state_q != ST_MM_START);
  assign mm_n_d        = load_cfg ? DIM_W'(LAYER_N[layer_idx_d]) : mm_n_q;
  assign mm_k_d        = load_cfg ? DIM_W'(LAYER_K[layer_idx_d]) : mm_k_q;
  assign relu_d_d      = load_cfg ? DIM_W'(LAYER_N[layer_idx_d]) : relu_d_q;
  assign src_sel_d     = load_cfg ? src_for_layer(layer_idx_d)   : src_sel_q;
  assign dst_sel_d     = load_cfg ? layer_idx_d[0]               : dst_sel_q;
  assign wgt_sel_d     = load_cfg ? layer_idx_d                  : wgt_sel_q;
  assign argmax_size_d = ((state_d == ST_ARGMAX_START) && (state_q != ST_ARGMAX_START))
                         ? DIM_W'(LAYER_N[LAST_LAYER]) : argmax_size_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      layer_idx_q   <= 2'd0;
      mm_n_q        <= '0;
      mm_k_q        <= '0;
      relu_d_q      <= '0;
      argmax_size_q <= '0;
      src_sel_q     <= 2'd0;
      dst_sel_q     <= 1'b0;
      wgt_sel_q     <= 2'd0;
      result_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      layer_idx_q   <= layer_idx_d;
      mm_n_q        <= mm_n_d;
      mm_k_q        <= mm_k_d;
      relu_d_q      <= relu_d_d;
      argmax_size_q <= argmax_size_d;
      src_sel_q     <= src_sel_d;
      dst_sel_q     <= dst_sel_d;
      wgt_sel_q     <= wgt_sel_d;
      result_q      <= result_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // The state preceding each wait state zeroes the count
  assign wd_clear  = (state_q == ST_IDLE) || (state_q == ST_MM_START) ||
                     (state_q == ST_RELU_START) || (state_q == ST_ARGMAX_START);
  assign wd_enable = (state_q == ST_WAIT_DATA) || (state_q == ST_MM_WAIT) ||
                     (state_q == ST_RELU_WAIT) || (state_q == ST_ARGMAX_WAIT);

  nn_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk    (clk),
    .resetn (resetn),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expire (wd_expire)
  );

  assign mm_start     = (state_q == ST_MM_START);
  assign relu_start   = (state_q == ST_RELU_START);
  assign argmax_start = (state_q == ST_ARGMAX_START);
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);
  assign mm_n         = mm_n_q;
  assign mm_k         = mm_k_q;
  assign relu_d       = relu_d_q;
  assign argmax_size  = argmax_size_q;
  assign src_sel      = src_sel_q;
  assign dst_sel      = dst_sel_q;
  assign wgt_sel      = wgt_sel_q;
  assign layer_idx    = layer_idx_q;
  assign result       = result_q;
  assign timeout_err  = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_nn_layer_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_nn_layer_sequencer : randomized runs against a layer-table model      |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_nn_layer_sequencer;

  localparam int TMO = 128;
  localparam int LIM = 400;
  localparam int EXP_N    [4] = '{64, 64, 32, 10};
  localparam int EXP_K    [4] = '{784, 64, 64, 32};
  localparam int EXP_RELU [4] = '{1, 1, 1, 0};

  logic       clk = 1'b0, resetn = 1'b0, start = 1'b0, abort = 1'b0, data_ready = 1'b0;
  logic       mm_done = 1'b0, relu_done = 1'b0, argmax_done = 1'b0;
  logic [3:0] argmax_index = 4'd0;
  logic       mm_start, relu_start, argmax_start, dst_sel, busy, done, timeout_err;
  logic [9:0] mm_n, mm_k, relu_d, argmax_size;
  logic [1:0] src_sel, wgt_sel, layer_idx;
  logic [3:0] result;

  int n_checks = 0, n_errors = 0;
  int n_mm = 0, n_relu = 0, n_am = 0, n_done = 0;
  int exp_result = 0, exp_terr = 0;

  nn_layer_sequencer #(
    .NUM_LAYERS(4), .DIM_W(10), .CLASS_W(4), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort), .data_ready(data_ready),
    .mm_done(mm_done), .relu_done(relu_done), .argmax_done(argmax_done),
    .argmax_index(argmax_index), .mm_start(mm_start), .mm_n(mm_n), .mm_k(mm_k),
    .relu_start(relu_start), .relu_d(relu_d), .argmax_start(argmax_start),
    .argmax_size(argmax_size), .src_sel(src_sel), .dst_sel(dst_sel), .wgt_sel(wgt_sel),
    .layer_idx(layer_idx), .busy(busy), .done(done), .result(result),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end

  // Ping-pong model: layer i writes buffer i%2, reads what layer i-1 wrote
  function automatic int exp_dst(input int i);
    return i % 2;
  endfunction
  function automatic int exp_src(input int i);
    if (i == 0) return 0;
    return (exp_dst(i - 1) == 0) ? 1 : 2;
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    if (mm_start)     n_mm++;
    if (relu_start)   n_relu++;
    if (argmax_start) n_am++;
    if (done)         n_done++;
  endtask

  function automatic logic sel_sig(input int w);
    case (w)
      0:       return mm_start;
      1:       return relu_start;
      2:       return argmax_start;
      default: return done;
    endcase
  endfunction

  task automatic wait_sig(input int w, input int exp_lat, input string tag);
    int c = 0;
    while (!sel_sig(w) && c < LIM) begin
      tick;
      c++;
    end
    check(tag, c, exp_lat);
  endtask

  task automatic pulse(input int w);
    case (w)
      0:       mm_done = 1'b1;
      1:       relu_done = 1'b1;
      default: argmax_done = 1'b1;
    endcase
    tick;
    mm_done = 1'b0; relu_done = 1'b0; argmax_done = 1'b0;
  endtask

  task automatic check_reset_values;
    check("rst_busy", busy, 0);         check("rst_mm_start", mm_start, 0);
    check("rst_mm_n", mm_n, 0);         check("rst_mm_k", mm_k, 0);
    check("rst_relu_d", relu_d, 0);     check("rst_argmax_size", argmax_size, 0);
    check("rst_src_sel", src_sel, 0);   check("rst_dst_sel", dst_sel, 0);
    check("rst_wgt_sel", wgt_sel, 0);   check("rst_layer_idx", layer_idx, 0);
    check("rst_result", result, 0);     check("rst_timeout_err", timeout_err, 0);
    check("rst_done", done, 0);
  endtask

  // mode 0: full run, 1: abort in relu wait of layer 2, 2: reset in mm wait of layer 1
  task automatic do_run(input int cls, input int dr_delay, input bit noisy, input int mode);
    int lat;
    n_mm = 0; n_relu = 0; n_am = 0; n_done = 0;
    data_ready = (dr_delay == 0);
    start = 1'b1; tick; start = 1'b0;
    exp_terr = 0;
    check("busy_after_start", busy, 1);
    check("terr_after_start", timeout_err, exp_terr);
    repeat (dr_delay) tick;
    if (dr_delay > 0) check("no_mm_before_data", n_mm, 0);
    data_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_sig(0, 1, "mm_start_lat");
      check("mm_n", mm_n, EXP_N[i]);
      check("mm_k", mm_k, EXP_K[i]);
      check("src_sel", src_sel, exp_src(i));
      check("dst_sel", dst_sel, exp_dst(i));
      check("wgt_sel", wgt_sel, i);
      check("layer_idx", layer_idx, i);
      if (noisy) begin mm_done = 1'b1; start = 1'b1; end
      tick;
      mm_done = 1'b0; start = 1'b0;
      check("mm_start_width", mm_start, 0);
      if (noisy) begin
        relu_done = 1'b1; argmax_done = 1'b1; argmax_index = 4'd15;
        tick;
        relu_done = 1'b0; argmax_done = 1'b0;
        check("noisy_relu_start", relu_start, 0);
        check("noisy_layer_idx", layer_idx, i);
        check("noisy_result", result, exp_result);
      end
      if (mode == 2 && i == 1) begin
        #2 resetn = 1'b0;
        #1;
        exp_result = 0; exp_terr = 0;
        check_reset_values();
        @(negedge clk);
        resetn = 1'b1;
        pulse(0);
        check("post_rst_mm_done_busy", busy, 0);
        pulse(1);
        check("post_rst_relu_start", relu_start, 0);
        return;
      end
      lat = $urandom_range(0, 5);
      repeat (lat) tick;
      pulse(0);
      if (EXP_RELU[i] != 0) begin
        wait_sig(1, 0, "relu_start_lat");
        check("relu_d", relu_d, EXP_N[i]);
        check("mm_n_stable", mm_n, EXP_N[i]);
        check("src_stable", src_sel, exp_src(i));
        tick;
        if (mode == 1 && i == 2) begin
          abort = 1'b1; tick; abort = 1'b0;
          check("abort_busy", busy, 0);
          check("abort_layer_idx", layer_idx, 0);
          check("abort_result", result, exp_result);
          check("abort_terr", timeout_err, exp_terr);
          return;
        end
        lat = $urandom_range(0, 5);
        repeat (lat) tick;
        pulse(1);
      end
    end
    wait_sig(2, 1, "argmax_start_lat");
    check("argmax_size", argmax_size, EXP_N[3]);
    check("argmax_src", dst_sel, exp_dst(3));
    tick;
    lat = $urandom_range(0, 5);
    repeat (lat) tick;
    argmax_index = 4'(cls);
    pulse(2);
    exp_result = cls;
    argmax_index = 4'($urandom_range(0, 15));
    wait_sig(3, 0, "done_lat");
    check("result", result, exp_result);
    tick;
    check("done_width", done, 0);
    check("idle_after_done", busy, 0);
    check("cnt_mm_start", n_mm, 4);
    check("cnt_relu_start", n_relu, 3);
    check("cnt_argmax_start", n_am, 1);
    check("cnt_done", n_done, 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_reset_values();
    resetn = 1'b1;
    tick;

    // Spurious done pulses and a start+abort collision while idle
    argmax_index = 4'd9; argmax_done = 1'b1; mm_done = 1'b1; relu_done = 1'b1;
    tick;
    argmax_done = 1'b0; mm_done = 1'b0; relu_done = 1'b0;
    check("idle_spurious_busy", busy, 0);
    check("idle_spurious_result", result, 0);
    start = 1'b1; abort = 1'b1; tick; start = 1'b0; abort = 1'b0;
    check("start_abort_idle", busy, 0);

    do_run(7, 0, 1'b0, 0);
    do_run($urandom_range(0, 15), 100, 1'b0, 0);
    do_run($urandom_range(0, 15), 0, 1'b1, 0);

    // Watchdog: no mm_done -> error exactly after TMO cycles in MM_WAIT
    data_ready = 1'b1;
    start = 1'b1; tick; start = 1'b0;
    wait_sig(0, 1, "tmo_mm_start");
    repeat (TMO) tick;
    check("tmo_not_yet", timeout_err, 0);
    tick;
    exp_terr = 1;
    check("tmo_err", timeout_err, exp_terr);
    check("tmo_busy", busy, 1);
    n_mm = 0;
    start = 1'b1; repeat (3) tick; start = 1'b0;
    check("err_no_start", n_mm, 0);
    check("err_terr_sticky", timeout_err, exp_terr);
    abort = 1'b1; tick; abort = 1'b0;
    check("err_abort_busy", busy, 0);
    check("err_abort_terr", timeout_err, exp_terr);

    // mm_done on the last allowed cycle beats the watchdog
    start = 1'b1; tick; start = 1'b0;
    exp_terr = 0;
    check("terr_clear_on_start", timeout_err, exp_terr);
    wait_sig(0, 1, "edge_mm_start");
    repeat (TMO) tick;
    pulse(0);
    check("edge_relu_start", relu_start, 1);
    check("edge_no_err", timeout_err, 0);
    abort = 1'b1; tick; abort = 1'b0;

    do_run($urandom_range(0, 15), 0, 1'b0, 1);
    do_run($urandom_range(0, 15), 0, 1'b0, 0);
    do_run($urandom_range(1, 15), 0, 1'b0, 2);
    do_run($urandom_range(0, 15), 0, 1'b0, 0);
    for (int r = 0; r < 4; r++)
      do_run($urandom_range(0, 15), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
